// File: rtl/evu_counter_bank.sv
// evu_counter_bank: NUM_CNT programmable event counters fed by evu_mux
// instances. Each counter drives its mux select and counts the returned
// event. Software access through a CSR port with registered reads.
// Overflow and threshold-crossing flags feed a level interrupt.
module evu_counter_bank #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CNT-1:0]   evt_i,
  output logic [4*NUM_CNT-1:0] sel_line_o,
  input  logic                 debug_mode_i,
  input  logic                 csr_we_i,
  input  logic                 csr_re_i,
  input  logic [4:0]           csr_addr_i,
  input  logic [CNT_W-1:0]     csr_wdata_i,
  output logic [CNT_W-1:0]     csr_rdata_o,
  output logic                 csr_rvalid_o,
  output logic                 irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Architectural state
  logic [CNT_W-1:0]   count_q  [NUM_CNT];
  logic [CNT_W-1:0]   count_d  [NUM_CNT];
  logic [CNT_W-1:0]   thresh_q [NUM_CNT];
  logic [CNT_W-1:0]   thresh_d [NUM_CNT];
  logic [3:0]         sel_q    [NUM_CNT];
  logic [3:0]         sel_d    [NUM_CNT];
  logic [NUM_CNT-1:0] en_q, en_d;
  logic [NUM_CNT-1:0] ovf_en_q, ovf_en_d;
  logic [NUM_CNT-1:0] thr_en_q, thr_en_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [NUM_CNT-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]   rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               irq_q, irq_d;

  // Per-counter decode and event qualification
  logic [NUM_CNT-1:0] wr_hit_s;
  logic [NUM_CNT-1:0] inc_s;
  logic [NUM_CNT-1:0] inc_eff_s;
  logic [NUM_CNT-1:0] ovf_set_s;
  logic [NUM_CNT-1:0] thr_set_s;
  logic [NUM_CNT-1:0] ovf_clr_s;
  logic [NUM_CNT-1:0] thr_clr_s;
  logic [CNT_W-1:0]   sum_s [NUM_CNT];
  logic [63:0]        wdata_ext_s;
  logic [63:0]        rd_val_s;

  // Write data widened so CTRL bits 8/9 exist even for narrow counters
  assign wdata_ext_s = 64'(csr_wdata_i);

  // Decode writes, qualify events, detect wrap and threshold crossing
  always_comb begin
    wr_hit_s  = '0;
    inc_s     = '0;
    inc_eff_s = '0;
    ovf_set_s = '0;
    thr_set_s = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      wr_hit_s[k]  = csr_we_i && (csr_addr_i[4:2] == 3'(k));
      inc_s[k]     = evt_i[k] && en_q[k] && !debug_mode_i;
      // A COUNT write in the same cycle drops the event
      inc_eff_s[k] = inc_s[k] && !(wr_hit_s[k] && (csr_addr_i[1:0] == 2'd0));
      sum_s[k]     = count_q[k] + CNT_W'(1);
      ovf_set_s[k] = inc_eff_s[k] && (count_q[k] == CNT_MAX);
      thr_set_s[k] = inc_eff_s[k] && (sum_s[k] == thresh_q[k]) &&
                     (thresh_q[k] != '0);
    end
  end

  // Next-state for counters, config registers and sticky flags
  always_comb begin
    en_d      = en_q;
    ovf_en_d  = ovf_en_q;
    thr_en_d  = thr_en_q;
    ovf_clr_s = '0;
    thr_clr_s = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      thresh_d[k] = thresh_q[k];
      sel_d[k]    = sel_q[k];
      if (wr_hit_s[k] && (csr_addr_i[1:0] == 2'd0)) begin
        count_d[k] = csr_wdata_i;
      end else if (inc_s[k]) begin
        count_d[k] = sum_s[k];
      end else begin
        count_d[k] = count_q[k];
      end
      if (wr_hit_s[k]) begin
        case (csr_addr_i[1:0])
          2'd1: begin
            en_d[k]     = wdata_ext_s[0];
            sel_d[k]    = wdata_ext_s[7:4];
            ovf_en_d[k] = wdata_ext_s[8];
            thr_en_d[k] = wdata_ext_s[9];
          end
          2'd2:    thresh_d[k] = csr_wdata_i;
          2'd3: begin
            ovf_clr_s[k] = wdata_ext_s[0];
            thr_clr_s[k] = wdata_ext_s[1];
          end
          default: thresh_d[k] = thresh_q[k];
        endcase
      end else begin
        thresh_d[k] = thresh_q[k];
      end
    end
    // Set beats a simultaneous write-1-to-clear
    ovf_d = (ovf_q & ~ovf_clr_s) | ovf_set_s;
    thr_d = (thr_q & ~thr_clr_s) | thr_set_s;
    irq_d = |((ovf_q & ovf_en_q) | (thr_q & thr_en_q));
  end

  // Read mux on current register values, so same-cycle writes read old data
  always_comb begin
    rd_val_s = 64'd0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (csr_addr_i[4:2] == 3'(k)) begin
        case (csr_addr_i[1:0])
          2'd0:    rd_val_s = 64'(count_q[k]);
          2'd1:    rd_val_s = {54'd0, thr_en_q[k], ovf_en_q[k], sel_q[k],
                               3'd0, en_q[k]};
          2'd2:    rd_val_s = 64'(thresh_q[k]);
          2'd3:    rd_val_s = {62'd0, thr_q[k], ovf_q[k]};
          default: rd_val_s = 64'd0;
        endcase
      end else begin
        rd_val_s = rd_val_s;
      end
    end
    if (csr_re_i) begin
      rdata_d = rd_val_s[CNT_W-1:0];
    end else begin
      rdata_d = rdata_q;
    end
    rvalid_d = csr_re_i;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        count_q[k]  <= '0;
        thresh_q[k] <= '0;
        sel_q[k]    <= 4'd0;
      end
      en_q     <= '0;
      ovf_en_q <= '0;
      thr_en_q <= '0;
      ovf_q    <= '0;
      thr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        count_q[k]  <= count_d[k];
        thresh_q[k] <= thresh_d[k];
        sel_q[k]    <= sel_d[k];
      end
      en_q     <= en_d;
      ovf_en_q <= ovf_en_d;
      thr_en_q <= thr_en_d;
      ovf_q    <= ovf_d;
      thr_q    <= thr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  // Pack the registered SEL fields onto the mux select bus
  always_comb begin
    sel_line_o = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      sel_line_o[4*k +: 4] = sel_q[k];
    end
  end

  assign csr_rdata_o  = rdata_q;
  assign csr_rvalid_o = rvalid_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_evu_counter_bank.sv
// Directed bench for evu_counter_bank (NUM_CNT=4, CNT_W=64).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_evu_counter_bank;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  evt_i;
  logic [15:0] sel_line_o;
  logic        debug_mode_i;
  logic        csr_we_i;
  logic        csr_re_i;
  logic [4:0]  csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic [63:0] csr_rdata_o;
  logic        csr_rvalid_o;
  logic        irq_o;

  int n_checks = 0;
  int n_err    = 0;

  evu_counter_bank #(.NUM_CNT(4), .CNT_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .evt_i(evt_i), .sel_line_o(sel_line_o),
    .debug_mode_i(debug_mode_i), .csr_we_i(csr_we_i), .csr_re_i(csr_re_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_rvalid_o(csr_rvalid_o), .irq_o(irq_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
    @(negedge clk_i);
    csr_we_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [63:0] exp, input string tag);
    csr_re_i = 1'b1; csr_addr_i = a;
    @(negedge clk_i);
    csr_re_i = 1'b0;
    chk({tag, "_rvalid"}, 64'(csr_rvalid_o), 64'd1);
    chk(tag, csr_rdata_o, exp);
    @(negedge clk_i);
    chk({tag, "_rvalid_low"}, 64'(csr_rvalid_o), 64'd0);
    chk({tag, "_hold"}, csr_rdata_o, exp);
  endtask

  initial begin
    rst_i = 1'b1; evt_i = 4'd0; debug_mode_i = 1'b0;
    csr_we_i = 1'b0; csr_re_i = 1'b0; csr_addr_i = 5'd0; csr_wdata_i = 64'd0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_sel", 64'(sel_line_o), 64'd0);
    chk("rst_rvalid", 64'(csr_rvalid_o), 64'd0);
    chk("rst_rdata", csr_rdata_o, 64'd0);
    for (int a = 0; a < 16; a++) rd(5'(a), 64'd0, "rst_reg");

    // Counter 0: EN, SEL=3, five events
    wr(5'd1, 64'h031);
    chk("sel0_after_wr", 64'(sel_line_o), 64'h0003);
    evt_i[0] = 1'b1;
    repeat (5) @(negedge clk_i);
    evt_i[0] = 1'b0;
    rd(5'd0, 64'd5, "count0_5");
    rd(5'd4, 64'd0, "count1_idle");
    rd(5'd8, 64'd0, "count2_idle");
    rd(5'd1, 64'h031, "ctrl0_rb");

    // Counter 1: wrap and overflow interrupt
    wr(5'd4, 64'hFFFF_FFFF_FFFF_FFFE);
    wr(5'd5, 64'h101);
    evt_i[1] = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("irq_ovf_not_yet", 64'(irq_o), 64'd0);
    @(negedge clk_i);
    chk("irq_ovf_rise", 64'(irq_o), 64'd1);
    evt_i[1] = 1'b0;
    rd(5'd4, 64'd1, "count1_wrap");
    rd(5'd7, 64'd1, "status1_ovf");
    wr(5'd7, 64'd1);
    chk("irq_ovf_lag", 64'(irq_o), 64'd1);
    @(negedge clk_i);
    chk("irq_ovf_fall", 64'(irq_o), 64'd0);
    rd(5'd7, 64'd0, "status1_clr");

    // Counter 2: threshold crossing
    wr(5'd10, 64'd4);
    wr(5'd9, 64'h201);
    evt_i[2] = 1'b1;
    repeat (3) @(negedge clk_i);
    evt_i[2] = 1'b0;
    rd(5'd11, 64'd0, "status2_below");
    evt_i[2] = 1'b1;
    @(negedge clk_i);
    evt_i[2] = 1'b0;
    chk("irq_thr_not_yet", 64'(irq_o), 64'd0);
    @(negedge clk_i);
    chk("irq_thr_rise", 64'(irq_o), 64'd1);
    rd(5'd11, 64'd2, "status2_thr");
    rd(5'd8, 64'd4, "count2_4");
    wr(5'd11, 64'd2);
    wr(5'd8, 64'd4);
    rd(5'd11, 64'd0, "status2_csr_wr_no_thr");
    chk("irq_thr_fall", 64'(irq_o), 64'd0);

    // Counter 2: W1C and setting event in the same cycle, set wins
    wr(5'd8, 64'd3);
    evt_i[2] = 1'b1;
    wr(5'd11, 64'd2);
    evt_i[2] = 1'b0;
    rd(5'd11, 64'd2, "status2_set_wins");
    rd(5'd8, 64'd4, "count2_after_set");
    wr(5'd11, 64'd2);

    // CTRL unused bits read 0; SEL drives the select bus
    wr(5'd13, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sel3_all", 64'(sel_line_o), 64'hF003);
    rd(5'd13, 64'h3F1, "ctrl3_mask");
    wr(5'd13, 64'h001);

    // Debug freeze, then COUNT write beats a same-cycle event
    debug_mode_i = 1'b1;
    evt_i[0] = 1'b1;
    repeat (3) @(negedge clk_i);
    evt_i[0] = 1'b0;
    debug_mode_i = 1'b0;
    rd(5'd0, 64'd5, "count0_debug");
    evt_i[0] = 1'b1;
    wr(5'd0, 64'h10);
    evt_i[0] = 1'b0;
    rd(5'd0, 64'h10, "count0_wr_wins");

    // Counter 3: same-cycle read and write returns the old value
    wr(5'd12, 64'd7);
    csr_we_i = 1'b1; csr_re_i = 1'b1; csr_addr_i = 5'd12; csr_wdata_i = 64'd9;
    @(negedge clk_i);
    csr_we_i = 1'b0; csr_re_i = 1'b0;
    chk("rw_same_rvalid", 64'(csr_rvalid_o), 64'd1);
    chk("rw_same_old", csr_rdata_o, 64'd7);
    rd(5'd12, 64'd9, "count3_new");

    // Reset mid-count with a read pending
    evt_i[0] = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1; csr_re_i = 1'b1; csr_addr_i = 5'd0;
    @(negedge clk_i);
    rst_i = 1'b0; csr_re_i = 1'b0; evt_i[0] = 1'b0;
    chk("mid_rst_rvalid", 64'(csr_rvalid_o), 64'd0);
    chk("mid_rst_rdata", csr_rdata_o, 64'd0);
    chk("mid_rst_irq", 64'(irq_o), 64'd0);
    chk("mid_rst_sel", 64'(sel_line_o), 64'd0);
    rd(5'd0, 64'd0, "mid_rst_count0");
    rd(5'd1, 64'd0, "mid_rst_ctrl0");
    rd(5'd10, 64'd0, "mid_rst_thresh2");
    rd(5'd12, 64'd0, "mid_rst_count3");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
